// File: rtl/alu_exec.sv
// Execute-stage ALU: single-cycle ARM data-processing, iterative MUL/MLA, NZCV.
// Define MUL_EARLY_TERM_EN to end a multiply once the remaining multiplier is zero.
module alu_exec #(
    parameter int         WIDTH     = 32,
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic             Mul,
    input  logic             Acc,
    input  logic [3:0]       ALUControl,
    input  logic             SetFlags,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic [WIDTH-1:0] SrcC,
    input  logic             ShiftCarry,
    output logic [WIDTH-1:0] Result,
    output logic             Done,
    output logic             WrValid,
    output logic             Busy,
    output logic [3:0]       Flags
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             s_q, s_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             wrvalid_q, wrvalid_d;
    logic [3:0]       flags_q, flags_d;

    logic [WIDTH-1:0] op_x, op_y, lres, dp_res;
    logic [WIDTH:0]   sum;
    logic             cin, arith, dp_c, dp_v, test_op;

    assign test_op = (ALUControl[3:2] == 2'b10);

    // Subtracts are x + ~y + cin so C comes out as NOT borrow.
    always_comb begin
        op_x  = SrcA;
        op_y  = SrcB;
        cin   = 1'b0;
        arith = 1'b1;
        lres  = '0;
        unique case (ALUControl)
            4'h0, 4'h8: begin lres = SrcA & SrcB; arith = 1'b0; end
            4'h1, 4'h9: begin lres = SrcA ^ SrcB; arith = 1'b0; end
            4'h2, 4'hA: begin op_y = ~SrcB; cin = 1'b1; end
            4'h3: begin op_x = SrcB; op_y = ~SrcA; cin = 1'b1; end
            4'h4, 4'hB: cin = 1'b0;
            4'h5: cin = flags_q[1];
            4'h6: begin op_y = ~SrcB; cin = flags_q[1]; end
            4'h7: begin op_x = SrcB; op_y = ~SrcA; cin = flags_q[1]; end
            4'hC: begin lres = SrcA | SrcB; arith = 1'b0; end
            4'hD: begin lres = SrcB; arith = 1'b0; end
            4'hE: begin lres = SrcA & ~SrcB; arith = 1'b0; end
            4'hF: begin lres = ~SrcB; arith = 1'b0; end
        endcase
        sum    = {1'b0, op_x} + {1'b0, op_y} + {{WIDTH{1'b0}}, cin};
        dp_res = arith ? sum[WIDTH-1:0] : lres;
        dp_c   = arith ? sum[WIDTH] : ShiftCarry;
        dp_v   = arith ? ((op_x[WIDTH-1] == op_y[WIDTH-1]) &&
                          (sum[WIDTH-1] != op_x[WIDTH-1]))
                       : flags_q[0];
    end

    logic [WIDTH-1:0] acc_step, mplier_nx;
    logic             last;

    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mplier_nx = mplier_q >> 1;
`ifdef MUL_EARLY_TERM_EN
    assign last = (cnt_q == LAST) || (mplier_nx == '0);
`else
    assign last = (cnt_q == LAST);
`endif

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        s_d       = s_q;
        result_d  = result_q;
        done_d    = 1'b0;
        wrvalid_d = 1'b0;
        flags_d   = flags_q;
        unique case (state_q)
            IDLE: begin
                if (Start && Mul) begin
                    state_d  = MUL;
                    mcand_d  = SrcA;
                    mplier_d = SrcB;
                    acc_d    = Acc ? SrcC : '0;
                    cnt_d    = '0;
                    s_d      = SetFlags;
                end else if (Start) begin
                    done_d    = 1'b1;
                    wrvalid_d = !test_op;
                    if (!test_op)
                        result_d = dp_res;
                    if (test_op || SetFlags)
                        flags_d = {dp_res[WIDTH-1], dp_res == '0, dp_c, dp_v};
                end
            end
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_nx;
                cnt_d    = cnt_q + CW'(1);
                if (last) begin
                    state_d   = IDLE;
                    result_d  = acc_step;
                    done_d    = 1'b1;
                    wrvalid_d = 1'b1;
                    if (s_q)
                        flags_d[3:2] = {acc_step[WIDTH-1], acc_step == '0};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            s_q       <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
            wrvalid_q <= 1'b0;
            flags_q   <= FLAGS_RST;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            s_q       <= s_d;
            result_q  <= result_d;
            done_q    <= done_d;
            wrvalid_q <= wrvalid_d;
            flags_q   <= flags_d;
        end
    end

    assign Result  = result_q;
    assign Done    = done_q;
    assign WrValid = wrvalid_q;
    assign Busy    = (state_q == MUL);
    assign Flags   = flags_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed bench for alu_exec: DP flags, MUL/MLA latency, reset abort.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Start = 1'b0;
    logic        Mul = 1'b0;
    logic        Acc = 1'b0;
    logic [3:0]  ALUControl = 4'h0;
    logic        SetFlags = 1'b0;
    logic [31:0] SrcA = '0;
    logic [31:0] SrcB = '0;
    logic [31:0] SrcC = '0;
    logic        ShiftCarry = 1'b0;
    logic [31:0] Result;
    logic        Done, WrValid, Busy;
    logic [3:0]  Flags;

    int tests = 0;
    int fails = 0;

    alu_exec #(.WIDTH(32), .FLAGS_RST(4'b0000)) dut (
        .clk(clk), .rst_n(rst_n), .Start(Start), .Mul(Mul), .Acc(Acc),
        .ALUControl(ALUControl), .SetFlags(SetFlags), .SrcA(SrcA),
        .SrcB(SrcB), .SrcC(SrcC), .ShiftCarry(ShiftCarry),
        .Result(Result), .Done(Done), .WrValid(WrValid), .Busy(Busy),
        .Flags(Flags)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic m, input logic a, input logic [3:0] op,
                         input logic s, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] z,
                         input logic sc);
        Start = 1'b1; Mul = m; Acc = a; ALUControl = op; SetFlags = s;
        SrcA = x; SrcB = y; SrcC = z; ShiftCarry = sc;
    endtask

    task automatic step;
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!Done && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic test_por;
        tests++;
        if ({Result, Done, WrValid, Busy, Flags} !== 39'd0) begin
            fails++;
            $display("FAIL por: got %h/%b%b%b/%b want all zero",
                     Result, Done, WrValid, Busy, Flags);
        end
    endtask

    task automatic test_add;
        drive(0, 0, 4'h4, 1, 32'hFFFF_FFFF, 32'd1, 0, 0);
        step();
        tests++;
        if ({Result, Done, WrValid, Busy, Flags} !== {32'd0, 3'b110, 4'b0110}) begin
            fails++;
            $display("FAIL add_s: got %h %b%b%b %b want 0 110 0110",
                     Result, Done, WrValid, Busy, Flags);
        end
        step();
        tests++;
        if (Done !== 1'b0) begin
            fails++;
            $display("FAIL add_pulse: Done=%b want 0", Done);
        end
    endtask

    task automatic test_cmp_adc;
        drive(0, 0, 4'hA, 0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        step();
        tests++;
        if ({Result, Done, WrValid, Flags} !== {32'd0, 2'b10, 4'b1001}) begin
            fails++;
            $display("FAIL cmp: got %h %b%b %b want 0 10 1001",
                     Result, Done, WrValid, Flags);
        end
        drive(0, 0, 4'h5, 0, 32'd5, 32'd3, 0, 0);
        step();
        tests++;
        if ({Result, Done, WrValid, Flags} !== {32'd8, 2'b11, 4'b1001}) begin
            fails++;
            $display("FAIL adc: got %0d %b%b %b want 8 11 1001",
                     Result, Done, WrValid, Flags);
        end
    endtask

    task automatic test_mov;
        drive(0, 0, 4'hD, 1, 32'h1234, 32'd0, 0, 1);
        step();
        tests++;
        if ({Result, WrValid, Flags} !== {32'd0, 1'b1, 4'b0111}) begin
            fails++;
            $display("FAIL mov_s: got %h %b %b want 0 1 0111",
                     Result, WrValid, Flags);
        end
    endtask

    task automatic test_sub_tst;
        drive(0, 0, 4'h2, 1, 32'd3, 32'd5, 0, 0);
        step();
        tests++;
        if ({Result, Flags} !== {32'hFFFF_FFFE, 4'b1000}) begin
            fails++;
            $display("FAIL sub_s: got %h %b want fffffffe 1000", Result, Flags);
        end
        drive(0, 0, 4'h8, 0, 32'hF0, 32'h0F, 0, 1);
        step();
        tests++;
        if ({Result, WrValid, Flags} !== {32'hFFFF_FFFE, 1'b0, 4'b0110}) begin
            fails++;
            $display("FAIL tst: got %h %b %b want fffffffe 0 0110",
                     Result, WrValid, Flags);
        end
    endtask

    task automatic test_mla;
        int n;
        int busy_bad;
        int exp_lat;
`ifdef MUL_EARLY_TERM_EN
        exp_lat = 13;
`else
        exp_lat = 32;
`endif
        busy_bad = 0;
        drive(1, 1, 4'h0, 1, 32'd1234, 32'd5678, 32'd10, 0);
        step();
        n = 0;
        while (!Done && n < 100) begin
            if (!Busy) busy_bad++;
            if (n == 3) drive(0, 0, 4'h4, 1, 32'd1, 32'd1, 0, 0);
            step();
            n++;
        end
        tests++;
        if (n !== exp_lat || busy_bad != 0) begin
            fails++;
            $display("FAIL mla_lat: got %0d (busy gaps %0d) want %0d",
                     n, busy_bad, exp_lat);
        end
        tests++;
        if ({Result, WrValid, Busy, Flags} !== {32'd7006662, 2'b10, 4'b0011}) begin
            fails++;
            $display("FAIL mla_res: got %0d %b%b %b want 7006662 10 0011",
                     Result, WrValid, Busy, Flags);
        end
        step();
        tests++;
        if (Done !== 1'b0 || Result !== 32'd7006662) begin
            fails++;
            $display("FAIL mla_noqueue: Done=%b Result=%0d want 0 7006662",
                     Done, Result);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        int l0, l3;
`ifdef MUL_EARLY_TERM_EN
        l0 = 1; l3 = 2;
`else
        l0 = 32; l3 = 32;
`endif
        drive(1, 0, 4'h0, 1, 32'd77, 32'd0, 32'd99, 0);
        step();
        wait_done(n);
        tests++;
        if (n !== l0 || Result !== 32'd0 || Flags !== 4'b0111) begin
            fails++;
            $display("FAIL mul_zero: lat %0d res %h flags %b want %0d 0 0111",
                     n, Result, Flags, l0);
        end
        drive(1, 0, 4'h0, 0, 32'h4000_0001, 32'd3, 0, 0);
        step();
        wait_done(n);
        tests++;
        if (n !== l3 || Result !== 32'hC000_0003 || Flags !== 4'b0111) begin
            fails++;
            $display("FAIL mul_3: lat %0d res %h flags %b want %0d c0000003 0111",
                     n, Result, Flags, l3);
        end
        drive(0, 0, 4'h4, 0, 32'd2, 32'd2, 0, 0);
        step();
        tests++;
        if ({Done, WrValid, Result} !== {2'b11, 32'd4}) begin
            fails++;
            $display("FAIL b2b_dp: got %b%b %0d want 11 4", Done, WrValid, Result);
        end
        drive(0, 0, 4'hF, 0, 32'd0, 32'd0, 0, 0);
        step();
        tests++;
        if ({Done, Result} !== {1'b1, 32'hFFFF_FFFF}) begin
            fails++;
            $display("FAIL b2b_mvn: got %b %h want 1 ffffffff", Done, Result);
        end
    endtask

    task automatic test_reset;
        int seen;
        drive(1, 0, 4'h0, 1, 32'd9, 32'hFFFF_FFFF, 0, 0);
        step();
        step();
        step();
        tests++;
        if (Busy !== 1'b1) begin
            fails++;
            $display("FAIL rst_busy: Busy=%b want 1", Busy);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({Result, Done, WrValid, Busy, Flags} !== 39'd0) begin
            fails++;
            $display("FAIL rst_mid: got %h %b%b%b %b want all zero",
                     Result, Done, WrValid, Busy, Flags);
        end
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (Done || Busy) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL rst_nodone: %0d active cycles want 0", seen);
        end
    endtask

    initial begin
        step();
        step();
        test_por();
        rst_n = 1'b1;
        step();
        test_add();
        test_cmp_adc();
        test_mov();
        test_mla();
        test_back_to_back();
        test_sub_tst();
        test_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
